count_sequence_monitor: RTL and testbench
=========================================

# count_sequence_monitor

Downstream consumer of the 3-bit mode-switchable counter (binary when M=0, reflected Gray when M=1). It samples Count and M every rising Clk edge and decodes Count to a linear index 0–7. It checks each sample against the legal successor of the previous one, and reports lock status, sequence errors and completed laps. It sits between the counter and the lab display/status logic.

## Interface
- ERR_W, 8, width of saturating error counter
- LAP_W, 4, width of wrapping lap counter
- Clk  input  1  clock; sampling on rising edge (counter updates on falling edge, so Count is stable half a cycle before each sample)
- nReset  input  1  reset, synchronous, active-low
- M  input  1  counter mode: 0 = binary, 1 = Gray
- Count  input  3  counter output
- Index  output  3  decoded position: Count when M=0, gray2bin(Count) when M=1
- Locked  output  1  monitor is tracking a verified sequence
- SeqError  output  1  one-cycle pulse on an illegal step
- ErrCount  output  ERR_W  number of SeqError pulses, saturating at all-ones
- Wrap  output  1  one-cycle pulse when a verified step goes from index 7 to index 0
- LapCount  output  LAP_W  number of Wrap pulses, modulo 2^LAP_W

## Operation
- Registers: state, prevIdx[2:0], prevM, goodRun[1:0], all outputs.
- Each sample computes curIdx = (M ? gray2bin(Count) : Count).
- Expected index is (prevIdx+1) mod 8 in both modes. A legal step is curIdx == expected.
- FSM states:
  - SYNC: no reference yet. Load prevIdx = curIdx and prevM = M. Go to VERIFY with goodRun = 0. No error or wrap is possible in SYNC.
  - VERIFY: on a legal step, goodRun++; when goodRun reaches 2, go to TRACK and set Locked = 1. On an illegal step, go back to VERIFY with goodRun = 0; no SeqError is raised, because the monitor is not yet locked.
  - TRACK: on a legal step, stay in TRACK. If prevIdx == 7, pulse Wrap and increment LapCount. On an illegal step, pulse SeqError, increment ErrCount (saturating), clear Locked and go to VERIFY with goodRun = 0.
- Every state loads prevIdx = curIdx and prevM = M on every sample.
- Mode change (M != prevM), in any state: treat as resync. Go to VERIFY with goodRun = 0 and clear Locked. Raise no SeqError and no Wrap.
- Mode change has priority over the legal/illegal check.
- The Wrap check uses prevIdx, not raw Count, so a wrap registers identically in both modes (111→000 binary, 100→000 Gray).
- Arithmetic: index increment is 3-bit modulo 8. ErrCount saturates at 2^ERR_W−1. LapCount rolls over to 0.

## Timing
- All outputs are registered. A sample on edge k is reflected in the outputs immediately after edge k, giving 1-cycle latency from a stable Count.
- Reset (nReset=0 at a rising edge) forces:
  - state = SYNC
  - Index = 0, Locked = 0, SeqError = 0, ErrCount = 0, Wrap = 0, LapCount = 0
  - prevIdx = 0, prevM = 0
- Reset mid-operation discards lock, errors and laps. The first edge after reset release is a SYNC sample.
- Minimum time from reset release to Locked = 1 is 3 rising edges: SYNC, then 2 legal steps.
- SeqError and Wrap are never asserted in the same cycle. Each is high for exactly one cycle per event.

## Structure
- Shared package count_mon_pkg holds:
  - state encoding constants (SYNC=2'd0, VERIFY=2'd1, TRACK=2'd2)
  - MODE_BIN = 1'b0, MODE_GRAY = 1'b1
  - function gray2bin3
- One sub-module, gray_to_bin3: purely combinational 3-bit Gray→binary, instantiated once for curIdx.
- FSM, prev registers and counters stay in count_sequence_monitor.

## Test plan
- Reset, then M=0 and the counter runs 000..111, 000 → Locked rises after the 3rd sample; Index tracks Count; Wrap is pulsed once on the 000 sample; LapCount=1; ErrCount=0.
- M=1 Gray run 000,001,011,010,110,111,101,100,000 → Index = 0..7,0; Wrap is pulsed on the final sample; no SeqError.
- While locked in binary, force Count 011→101 → SeqError pulses for one cycle; ErrCount=1; Locked=0; Locked returns after 2 further legal steps.
- Toggle M mid-run while locked → Locked drops and no SeqError is raised; Locked relocks after 2 legal steps in the new mode.
- Inject 2^ERR_W+3 errors by alternating illegal and legal steps → ErrCount holds at 255 (ERR_W=8).
- Assert nReset low for one edge mid-run with LapCount=5 → all outputs return to 0; relock takes 3 edges.

Source files
------------

// File: rtl/count_mon_pkg.sv
// count_mon_pkg
//   Shared definitions for the count sequence monitor:
//   - state_t   : monitor FSM states (SYNC, VERIFY, TRACK)
//   - MODE_BIN / MODE_GRAY : values of the counter mode input M
//   - gray2bin3 : 3-bit reflected Gray to binary conversion
package count_mon_pkg;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      VERIFY = 2'd1,
      TRACK  = 2'd2
   } state_t;

   localparam logic MODE_BIN  = 1'b0;
   localparam logic MODE_GRAY = 1'b1;

   function automatic logic [2:0] gray2bin3(input logic [2:0] g);
      return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
   endfunction

endpackage

// File: rtl/count_sequence_monitor_gray_to_bin3.sv
// gray_to_bin3
//   Purely combinational 3-bit reflected Gray to binary converter.
//   Ports:
//     gray  input  [2:0]  Gray-coded value
//     bin   output [2:0]  equivalent binary value
module gray_to_bin3
   import count_mon_pkg::*;
(
   input  logic [2:0] gray,
   output logic [2:0] bin
);

   always_comb begin
      bin = gray2bin3(gray);
   end

endmodule

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
//   Samples a 3-bit binary/Gray counter every rising Clk edge, decodes it to
//   a linear index and checks each sample against the legal successor of the
//   previous one. Reports lock status, sequence errors and completed laps.
//   Ports:
//     Clk       input             sampling clock (rising edge)
//     nReset    input             synchronous active-low reset
//     M         input             counter mode: 0 = binary, 1 = Gray
//     Count     input  [2:0]      counter value
//     Index     output [2:0]      decoded index of the last sample
//     Locked    output            tracking a verified sequence
//     SeqError  output            one-cycle pulse on an illegal step while locked
//     ErrCount  output [ERR_W-1:0] saturating count of SeqError pulses
//     Wrap      output            one-cycle pulse on a verified 7 -> 0 step
//     LapCount  output [LAP_W-1:0] wrapping count of Wrap pulses
module count_sequence_monitor
   import count_mon_pkg::*;
#(
   parameter int ERR_W = 8,
   parameter int LAP_W = 4
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             M,
   input  logic [2:0]       Count,
   output logic [2:0]       Index,
   output logic             Locked,
   output logic             SeqError,
   output logic [ERR_W-1:0] ErrCount,
   output logic             Wrap,
   output logic [LAP_W-1:0] LapCount
);

   state_t     state, state_n;
   logic [2:0] prevIdx;
   logic       prevM;
   logic [1:0] goodRun, goodRun_n;
   logic [2:0] grayIdx, curIdx, expIdx;
   logic       legal;
   logic       locked_n, seqErr_n, wrap_n;

   gray_to_bin3 u_gray_to_bin3 (
      .gray (Count),
      .bin  (grayIdx)
   );

   always_comb begin
      curIdx    = (M == MODE_GRAY) ? grayIdx : Count;
      expIdx    = prevIdx + 3'd1;
      legal     = (curIdx == expIdx);
      state_n   = state;
      goodRun_n = goodRun;
      locked_n  = Locked;
      seqErr_n  = 1'b0;
      wrap_n    = 1'b0;

      // A mode change invalidates the reference in every state and wins over
      // the legal/illegal decision, so it never produces SeqError or Wrap.
      if (M != prevM) begin
         state_n   = VERIFY;
         goodRun_n = 2'd0;
         locked_n  = 1'b0;
      end else begin
         unique case (state)
            SYNC: begin
               state_n   = VERIFY;
               goodRun_n = 2'd0;
               locked_n  = 1'b0;
            end
            VERIFY: begin
               if (legal) begin
                  if (goodRun == 2'd1) begin
                     state_n   = TRACK;
                     goodRun_n = 2'd2;
                     locked_n  = 1'b1;
                  end else begin
                     goodRun_n = goodRun + 2'd1;
                  end
               end else begin
                  goodRun_n = 2'd0;
               end
            end
            TRACK: begin
               if (legal) begin
                  // Wrap keys off the previous decoded index so both modes
                  // register a lap on the same logical step.
                  wrap_n = (prevIdx == 3'd7);
               end else begin
                  seqErr_n  = 1'b1;
                  locked_n  = 1'b0;
                  state_n   = VERIFY;
                  goodRun_n = 2'd0;
               end
            end
            default: begin
               state_n   = SYNC;
               goodRun_n = 2'd0;
               locked_n  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!nReset) begin
         state    <= SYNC;
         prevIdx  <= '0;
         prevM    <= MODE_BIN;
         goodRun  <= '0;
         Index    <= '0;
         Locked   <= 1'b0;
         SeqError <= 1'b0;
         Wrap     <= 1'b0;
         ErrCount <= '0;
         LapCount <= '0;
      end else begin
         state    <= state_n;
         prevIdx  <= curIdx;
         prevM    <= M;
         goodRun  <= goodRun_n;
         Index    <= curIdx;
         Locked   <= locked_n;
         SeqError <= seqErr_n;
         Wrap     <= wrap_n;
         if (seqErr_n && (ErrCount != '1)) begin
            ErrCount <= ErrCount + ERR_W'(1);
         end
         if (wrap_n) begin
            LapCount <= LapCount + LAP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_count_sequence_monitor.sv
module tb_count_sequence_monitor;

   localparam int ERR_W = 8;
   localparam int LAP_W = 4;

   logic             Clk = 1'b0;
   logic             nReset = 1'b0;
   logic             M = 1'b0;
   logic [2:0]       Count = 3'd0;
   logic [2:0]       Index;
   logic             Locked;
   logic             SeqError;
   logic [ERR_W-1:0] ErrCount;
   logic             Wrap;
   logic [LAP_W-1:0] LapCount;

   count_sequence_monitor #(
      .ERR_W (ERR_W),
      .LAP_W (LAP_W)
   ) dut (
      .Clk      (Clk),
      .nReset   (nReset),
      .M        (M),
      .Count    (Count),
      .Index    (Index),
      .Locked   (Locked),
      .SeqError (SeqError),
      .ErrCount (ErrCount),
      .Wrap     (Wrap),
      .LapCount (LapCount)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [2:0]       idx;
      logic             lk;
      logic             se;
      logic             wr;
      logic [ERR_W-1:0] ec;
      logic [LAP_W-1:0] lc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s sample %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Inputs change on the falling edge; the expectation for the following
   // rising-edge sample is queued at the same time.
   task automatic step(input logic rn, input logic m, input logic [2:0] c,
                       input logic [2:0] idx, input logic lk, input logic se,
                       input logic wr, input int ec, input int lc);
      exp_t e;
      @(negedge Clk);
      nReset = rn;
      M      = m;
      Count  = c;
      e.idx  = idx;
      e.lk   = lk;
      e.se   = se;
      e.wr   = wr;
      e.ec   = ec[ERR_W-1:0];
      e.lc   = lc[LAP_W-1:0];
      q.push_back(e);
   endtask

   function automatic logic [2:0] bin2gray(input logic [2:0] b);
      return b ^ (b >> 1);
   endfunction

   // Monitor: every rising edge presents a new registered result.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cyc++;
            chk("Index",    int'(Index),    int'(e.idx));
            chk("Locked",   int'(Locked),   int'(e.lk));
            chk("SeqError", int'(SeqError), int'(e.se));
            chk("Wrap",     int'(Wrap),     int'(e.wr));
            chk("ErrCount", int'(ErrCount), int'(e.ec));
            chk("LapCount", int'(LapCount), int'(e.lc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] gseq [9];
      logic [2:0] p;
      logic [2:0] qi;
      int         ec;
      int         wait_cyc;

      gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
               3'b111, 3'b101, 3'b100, 3'b000};

      // Reset state
      step(1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);

      // Binary run 0..7,0: lock on 3rd sample, wrap on the 0 sample
      for (int unsigned i = 0; i < 8; i++)
         step(1'b1, 1'b0, 3'(i), 3'(i), (i >= 2), 1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 0, 1);
      step(1'b1, 1'b0, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 0, 1);

      // Gray run (mode change on first sample resyncs), wrap on final 000
      for (int unsigned i = 0; i < 9; i++)
         step(1'b1, 1'b1, gseq[i], 3'(i % 8), (i >= 2), 1'b0,
              (i == 8), 0, (i == 8) ? 2 : 1);

      // Binary relock, then illegal 3 -> 5 while locked
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 2);
      step(1'b1, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 0, 2);
      step(1'b1, 1'b0, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0, 0, 2);
      step(1'b1, 1'b0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0, 0, 2);
      step(1'b1, 1'b0, 3'd5, 3'd5, 1'b0, 1'b1, 1'b0, 1, 2);
      step(1'b1, 1'b0, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0, 1, 2);
      step(1'b1, 1'b0, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1, 2);
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1, 3);

      // Mode toggle while locked on an otherwise legal step: no SeqError
      step(1'b1, 1'b1, 3'b001, 3'd1, 1'b0, 1'b0, 1'b0, 1, 3);
      step(1'b1, 1'b1, 3'b011, 3'd2, 1'b0, 1'b0, 1'b0, 1, 3);
      step(1'b1, 1'b1, 3'b010, 3'd3, 1'b1, 1'b0, 1'b0, 1, 3);

      // 2^ERR_W+3 locked errors: illegal skip, then two legal steps to relock
      p  = 3'd3;
      ec = 1;
      for (int unsigned k = 0; k < 259; k++) begin
         qi = p + 3'd2;
         ec = (ec < 255) ? ec + 1 : 255;
         step(1'b1, 1'b1, bin2gray(qi), qi, 1'b0, 1'b1, 1'b0, ec, 3);
         qi = qi + 3'd1;
         step(1'b1, 1'b1, bin2gray(qi), qi, 1'b0, 1'b0, 1'b0, ec, 3);
         qi = qi + 3'd1;
         step(1'b1, 1'b1, bin2gray(qi), qi, 1'b1, 1'b0, 1'b0, ec, 3);
         p = qi;
      end

      // Back to binary; illegal step while verifying raises no SeqError
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 255, 3);
      step(1'b1, 1'b0, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 255, 3);
      step(1'b1, 1'b0, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0, 255, 3);
      step(1'b1, 1'b0, 3'd5, 3'd5, 1'b1, 1'b0, 1'b0, 255, 3);
      step(1'b1, 1'b0, 3'd6, 3'd6, 1'b1, 1'b0, 1'b0, 255, 3);
      step(1'b1, 1'b0, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 255, 3);
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 255, 4);
      for (int unsigned i = 1; i < 8; i++)
         step(1'b1, 1'b0, 3'(i), 3'(i), 1'b1, 1'b0, 1'b0, 255, 4);
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 255, 5);

      // One-edge reset mid-run with LapCount=5, then relock in 3 edges
      step(1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 3'd5, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 3'd6, 3'd6, 1'b1, 1'b0, 1'b0, 0, 0);

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(posedge Clk);
         wait_cyc++;
      end
      @(negedge Clk);
      chk("scoreboard_drain", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
